// File: rtl/mskrnd_hpc3_src.sv
// Fresh-randomness source for HPC3 gadgets: a bank of seeded 32-bit LFSR lanes,
// warmed up after seeding, then stepped 32 ticks per accepted rnd transfer.
`timescale 1ns/1ps
module mskrnd_hpc3_src #(
  parameter int unsigned d      = 2,
  parameter int unsigned WARMUP = 16,
  localparam int unsigned HPC3RND = d * (d - 1),
  localparam int unsigned NL      = (HPC3RND + 31) / 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        seed_in,
  input  logic               seed_valid,
  output logic               seed_ready,
  input  logic               reseed,
  output logic [HPC3RND-1:0] rnd_out,
  output logic               rnd_valid,
  input  logic               rnd_ready,
  output logic               busy
);

  localparam int unsigned SCW = (NL > 1) ? $clog2(NL) : 1;
  localparam int unsigned WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [SCW-1:0] SeedLast = SCW'(NL - 1);
  localparam logic [WCW-1:0] WarmLast = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);

  typedef enum logic [1:0] {StLoad, StWarm, StRun} state_e;

  state_e         state_q, state_d;
  logic [SCW-1:0] seed_cnt_q, seed_cnt_d;
  logic [WCW-1:0] warm_cnt_q, warm_cnt_d;
  logic [31:0]    lane_q [NL];
  logic [31:0]    lane_d [NL];
  logic [31:0]    lane_adv [NL];
  logic [HPC3RND-1:0] rnd_word;

  // 32 unrolled LFSR ticks, taps 31/21/1/0.
  function automatic logic [31:0] advance32(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int i = 0; i < 32; i++) begin
      t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
    end
    return t;
  endfunction

  always_comb begin
    for (int i = 0; i < NL; i++) begin
      lane_adv[i] = advance32(lane_q[i]);
    end
  end

  always_comb begin
    rnd_word = '0;
    for (int i = 0; i < HPC3RND; i++) begin
      rnd_word[i] = lane_q[i / 32][i % 32];
    end
  end

  always_comb begin
    state_d    = state_q;
    seed_cnt_d = seed_cnt_q;
    warm_cnt_d = warm_cnt_q;
    lane_d     = lane_q;
    if (reseed) begin
      // Lanes keep old contents; a concurrent transfer is consumed without advancing.
      state_d    = StLoad;
      seed_cnt_d = '0;
      warm_cnt_d = '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (seed_valid) begin
            for (int i = 0; i < NL; i++) begin
              if (seed_cnt_q == SCW'(i)) begin
                lane_d[i] = (seed_in == 32'h0) ? 32'h0000_0001 : seed_in;
              end
            end
            if (seed_cnt_q == SeedLast) begin
              seed_cnt_d = '0;
              warm_cnt_d = '0;
              state_d    = (WARMUP == 0) ? StRun : StWarm;
            end else begin
              seed_cnt_d = seed_cnt_q + 1'b1;
            end
          end
        end
        StWarm: begin
          lane_d = lane_adv;
          if (warm_cnt_q == WarmLast) begin
            warm_cnt_d = '0;
            state_d    = StRun;
          end else begin
            warm_cnt_d = warm_cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (rnd_ready) begin
            lane_d = lane_adv;
          end
        end
        default: state_d = StLoad;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StLoad;
      seed_cnt_q <= '0;
      warm_cnt_q <= '0;
      for (int i = 0; i < NL; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      seed_cnt_q <= seed_cnt_d;
      warm_cnt_q <= warm_cnt_d;
      lane_q     <= lane_d;
    end
  end

  always_comb begin
    seed_ready = (state_q == StLoad);
    rnd_valid  = (state_q == StRun);
    busy       = (state_q != StRun);
    rnd_out    = rnd_valid ? rnd_word : '0;
  end

endmodule

// File: tb/tb_mskrnd_hpc3_src.sv
// Scoreboard bench: two instances (d=2/WARMUP=0 and d=9/WARMUP=16) checked against
// a word-stream reference model built from the LFSR rule.
`timescale 1ns/1ps
module tb_mskrnd_hpc3_src;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a_seed_in, b_seed_in;
  logic        a_seed_valid, b_seed_valid, a_seed_ready, b_seed_ready;
  logic        a_reseed, b_reseed, a_valid, b_valid, a_ready, b_ready, a_busy, b_busy;
  logic [1:0]  a_out;
  logic [71:0] b_out;

  mskrnd_hpc3_src #(.d(2), .WARMUP(0)) u_a (
    .clk(clk), .rst(rst), .seed_in(a_seed_in), .seed_valid(a_seed_valid),
    .seed_ready(a_seed_ready), .reseed(a_reseed), .rnd_out(a_out), .rnd_valid(a_valid),
    .rnd_ready(a_ready), .busy(a_busy)
  );

  mskrnd_hpc3_src #(.d(9), .WARMUP(16)) u_b (
    .clk(clk), .rst(rst), .seed_in(b_seed_in), .seed_valid(b_seed_valid),
    .seed_ready(b_seed_ready), .reseed(b_reseed), .rnd_out(b_out), .rnd_valid(b_valid),
    .rnd_ready(b_ready), .busy(b_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int b_xfers = 0;
  int b_hs    = 0;
  logic [71:0] exp_a[$];
  logic [71:0] exp_b[$];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one lane step is 32 applications of the feedback rule.
  function automatic logic [31:0] adv(input logic [31:0] s);
    logic [31:0] x;
    x = s;
    repeat (32) x = (x << 1) | 32'(((x >> 31) ^ (x >> 21) ^ (x >> 1) ^ x) & 32'd1);
    return x;
  endfunction

  // Expected word stream after seeding s0..s2 and discarding `warm` steps.
  task automatic push_expected(input int inst, input logic [31:0] s0, input logic [31:0] s1,
                               input logic [31:0] s2, input int warm, input int n);
    logic [31:0] st[3];
    st[0] = (s0 == 0) ? 32'd1 : s0;
    st[1] = (s1 == 0) ? 32'd1 : s1;
    st[2] = (s2 == 0) ? 32'd1 : s2;
    repeat (warm) for (int i = 0; i < 3; i++) st[i] = adv(st[i]);
    for (int k = 0; k < n; k++) begin
      if (inst == 0) exp_a.push_back({70'd0, st[0][1:0]});
      else exp_b.push_back({st[2][7:0], st[1], st[0]});
      for (int i = 0; i < 3; i++) st[i] = adv(st[i]);
    end
  endtask

  // Monitor: every visible word must match the queue head; a transfer pops it.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_valid) begin
        if (exp_a.size() == 0) check("a_unexpected_word", {70'd0, a_out}, 72'hX);
        else begin
          check("a_word", {70'd0, a_out}, exp_a[0]);
          if (a_ready) void'(exp_a.pop_front());
        end
      end else check("a_out_zero_when_invalid", {70'd0, a_out}, 72'd0);
      if (b_valid) begin
        if (exp_b.size() == 0) check("b_unexpected_word", b_out, 72'hX);
        else begin
          check("b_word", b_out, exp_b[0]);
          if (b_ready) begin
            void'(exp_b.pop_front());
            b_xfers++;
          end
        end
      end else check("b_out_zero_when_invalid", b_out, 72'd0);
      if (b_seed_valid && b_seed_ready) b_hs++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seed_b(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                        input int gap);
    logic [31:0] w[3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    for (int i = 0; i < 3; i++) begin
      b_seed_in = w[i];
      b_seed_valid = 1'b1;
      tick();
      b_seed_valid = 1'b0;
      if (i < 2) repeat (gap) tick();
    end
  endtask

  task automatic wait_b_valid(output int cyc);
    cyc = 1;
    while (!b_valid && cyc < 60) begin
      b_ready = 1'($urandom_range(0, 1));
      if (cyc == 5) begin
        b_seed_valid = 1'b1;
        b_seed_in = $urandom;
      end else b_seed_valid = 1'b0;
      tick();
      cyc++;
    end
    b_seed_valid = 1'b0;
    b_ready = 1'b0;
  endtask

  task automatic run_b(input int n);
    int cyc;
    cyc = 0;
    b_xfers = 0;
    while (b_xfers < n && cyc < 20 * n) begin
      b_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    b_ready = 1'b0;
    check("b_transfer_count", 72'(b_xfers), 72'(n));
  endtask

  initial begin
    logic [31:0] r0, r1, r2;
    int cyc;
    a_seed_in = '0; a_seed_valid = 0; a_reseed = 0; a_ready = 0;
    b_seed_in = '0; b_seed_valid = 0; b_reseed = 0; b_ready = 0;
    #1;
    check("a_reset_seed_ready", 72'(a_seed_ready), 72'd1);
    check("a_reset_valid", 72'(a_valid), 72'd0);
    check("a_reset_busy", 72'(a_busy), 72'd1);
    check("b_reset_seed_ready", 72'(b_seed_ready), 72'd1);
    check("b_reset_valid_out", {b_out[70:0], b_valid}, 72'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Instance a: WARMUP=0, single seed, word visible one cycle after acceptance.
    push_expected(0, 32'hDEADBEEF, 0, 0, 0, 40);
    a_seed_in = 32'hDEADBEEF;
    a_seed_valid = 1'b1;
    check("a_seed_ready_before", 72'(a_seed_ready), 72'd1);
    tick();
    a_seed_valid = 1'b0;
    check("a_seed_ready_after", 72'(a_seed_ready), 72'd0);
    check("a_valid_after_seed", 72'(a_valid), 72'd1);
    check("a_first_word", 72'(a_out), 72'd3);
    check("a_busy_run", 72'(a_busy), 72'd0);
    repeat (3) tick();
    for (int i = 0; i < 15; i++) begin
      a_ready = 1'($urandom_range(0, 1));
      tick();
    end
    a_ready = 1'b0;
    a_reseed = 1'b1;
    tick();
    a_reseed = 1'b0;
    exp_a.delete();
    check("a_reseed_seed_ready", 72'(a_seed_ready), 72'd1);
    push_expected(0, 32'h0, 0, 0, 0, 10);
    a_seed_in = 32'h0;
    a_seed_valid = 1'b1;
    tick();
    a_seed_valid = 1'b0;
    check("a_zero_seed_word", 72'(a_out), 72'd1);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    r0 = adv(32'd1);
    check("a_after_one_step", 72'(a_out), 72'(r0[1:0]));

    // Instance b: 3 gapped seeds, warm-up latency, ignored seed/ready during WARM.
    r0 = $urandom; r1 = 32'h0; r2 = $urandom;
    push_expected(1, r0, r1, r2, 16, 1200);
    b_hs = 0;
    seed_b(r0, r1, r2, 1);
    check("b_busy_warm", 72'(b_busy), 72'd1);
    wait_b_valid(cyc);
    check("b_latency", 72'(cyc), 72'd17);
    check("b_handshakes", 72'(b_hs), 72'd3);
    run_b(1000);

    // Reseed in RUN with a concurrent transfer, then reseed colliding with a seed word.
    b_ready = 1'b1;
    b_reseed = 1'b1;
    tick();
    b_reseed = 1'b0;
    b_ready = 1'b0;
    exp_b.delete();
    check("b_reseed_valid", 72'(b_valid), 72'd0);
    check("b_reseed_out", b_out, 72'd0);
    check("b_reseed_seed_ready", 72'(b_seed_ready), 72'd1);
    b_reseed = 1'b1;
    b_seed_valid = 1'b1;
    b_seed_in = 32'h1234_5678;
    tick();
    b_reseed = 1'b0;
    b_seed_valid = 1'b0;
    r0 = $urandom; r1 = $urandom; r2 = $urandom;
    push_expected(1, r0, r1, r2, 16, 100);
    seed_b(r0, r1, r2, 0);
    wait_b_valid(cyc);
    check("b_latency_reseed", 72'(cyc), 72'd17);
    run_b(50);

    // Asynchronous reset mid-WARM.
    b_reseed = 1'b1;
    tick();
    b_reseed = 1'b0;
    exp_b.delete();
    seed_b($urandom, $urandom, $urandom, 0);
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    exp_a.delete();
    exp_b.delete();
    check("b_async_seed_ready", 72'(b_seed_ready), 72'd1);
    check("b_async_valid", 72'(b_valid), 72'd0);
    check("b_async_busy", 72'(b_busy), 72'd1);
    check("b_async_out", b_out, 72'd0);
    check("a_async_valid", 72'(a_valid), 72'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      b_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("b_no_word_after_rst", 72'(b_valid), 72'd0);
    b_ready = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

endmodule
